// File: rtl/dft_seq_ctrl.sv
// dft_seq_ctrl: sequencer for the direct-DFT datapath.
// Loads N samples into the compute cache, then for every bin k clears the
// accumulator, walks n = 0..N-1 with twiddle index (n*k) mod N, strobes the
// bin result, and finally strobes done.
// Optional feature: define DFT_SEQ_CTRL_ABORT_EN to add the `abort` input.
module dft_seq_ctrl #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          ce,
  input  logic          start,
  input  logic [AW-1:0] sample_num,
`ifdef DFT_SEQ_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          load_ncompute,
  output logic          cache_we,
  output logic [AW-1:0] cache_adr,
  output logic [AW-1:0] n_idx,
  output logic [AW-1:0] k_idx,
  output logic [AW-1:0] tw_idx,
  output logic          acc_clear,
  output logic          acc_en,
  output logic          bin_valid,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_COMPUTE, S_DUMP, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] nm1, nm1_nx;
  logic [AW-1:0] adr_q, adr_nx;
  logic [AW-1:0] n_q, n_nx;
  logic [AW-1:0] k_q, k_nx;
  logic [AW-1:0] tw_q, tw_nx;

  // Transform length and twiddle sum need one extra bit: N can be 2**AW and
  // tw+k can reach 2N-2.
  logic [AW:0]   n_len;
  logic [AW:0]   tw_sum;
  logic [AW:0]   tw_wrapped;
  logic [AW-1:0] tw_step;
  logic          tw_unused;
  logic          abort_req;

  assign n_len      = {1'b0, nm1} + (AW+1)'(1);
  assign tw_sum     = {1'b0, tw_q} + {1'b0, k_q};
  assign tw_wrapped = (tw_sum >= n_len) ? (tw_sum - n_len) : tw_sum;
  assign tw_step    = tw_wrapped[AW-1:0];
  assign tw_unused  = tw_wrapped[AW];

`ifdef DFT_SEQ_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign busy          = (state != S_IDLE);
  assign load_ncompute = (state == S_IDLE) || (state == S_LOAD);
  assign cache_adr     = adr_q;
  assign n_idx         = n_q;
  assign k_idx         = k_q;
  assign tw_idx        = tw_q;

  // Next-state, counter update and ce-qualified strobe decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nx  = state;
    nm1_nx    = nm1;
    adr_nx    = adr_q;
    n_nx      = n_q;
    k_nx      = k_q;
    tw_nx     = tw_q;
    cache_we  = 1'b0;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    bin_valid = 1'b0;
    done      = 1'b0;
    if (ce) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nx = S_LOAD;
            nm1_nx   = sample_num;
            adr_nx   = '0;
          end
        end
        S_LOAD: begin
          cache_we = 1'b1;
          if (adr_q == nm1) begin
            state_nx = S_CLEAR;
            k_nx     = '0;
          end else begin
            adr_nx = adr_q + AW'(1);
          end
        end
        S_CLEAR: begin
          acc_clear = 1'b1;
          n_nx      = '0;
          tw_nx     = '0;
          state_nx  = S_COMPUTE;
        end
        S_COMPUTE: begin
          acc_en = 1'b1;
          if (n_q == nm1) begin
            state_nx = S_DUMP;
          end else begin
            n_nx  = n_q + AW'(1);
            tw_nx = tw_step;
          end
        end
        S_DUMP: begin
          bin_valid = 1'b1;
          if (k_q == nm1) begin
            state_nx = S_DONE;
          end else begin
            k_nx     = k_q + AW'(1);
            state_nx = S_CLEAR;
          end
        end
        S_DONE: begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
      // Abort drops the transform; the strobe of the current cycle still stands.
      if (abort_req && (state != S_IDLE)) begin
        state_nx = S_IDLE;
        nm1_nx   = '0;
        adr_nx   = '0;
        n_nx     = '0;
        k_nx     = '0;
        tw_nx    = '0;
      end
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nrst) begin
      // NOTE: these are plain flops (no RAM here), so every one of them is reset.
      state <= S_IDLE;
      nm1   <= '0;
      adr_q <= '0;
      n_q   <= '0;
      k_q   <= '0;
      tw_q  <= '0;
    end else begin
      state <= state_nx;
      nm1   <= nm1_nx;
      adr_q <= adr_nx;
      n_q   <= n_nx;
      k_q   <= k_nx;
      tw_q  <= tw_nx;
    end
  end

endmodule
